// File: rtl/ip4_rtl_spa_wbq_if.sv
// Bundle of the SPA result push bus and the per-bank RF write bus of the write-back queue.
// The queue itself connects through the slave modport; the SPA/RF side uses master.
interface ip4_rtl_spa_wbq_if #(
  parameter int NUM_FU    = 3,
  parameter int NUM_SP    = 8,
  parameter int WORD_BITS = 32,
  parameter int NUM_BK    = 4,
  parameter int ADR_BITS  = 6,
  parameter int TID_BITS  = 3,
  parameter int DEPTH     = 8
);
  localparam int BK_W  = $clog2(NUM_BK);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_FU-1:0]                  in_en;
  logic [NUM_FU*BK_W-1:0]             in_bk;
  logic [NUM_FU*ADR_BITS-1:0]         in_adr;
  logic [TID_BITS-1:0]                in_tid;
  logic [NUM_FU*NUM_SP-1:0]           in_emsk;
  logic [NUM_FU*NUM_SP*WORD_BITS-1:0] in_data;
  logic                               stall;
  logic [NUM_BK-1:0]                  wr_en;
  logic [NUM_BK*ADR_BITS-1:0]         wr_adr;
  logic [NUM_BK*TID_BITS-1:0]         wr_tid;
  logic [NUM_BK*NUM_SP-1:0]           wr_emsk;
  logic [NUM_BK*NUM_SP*WORD_BITS-1:0] wr_data;
  logic [CNT_W-1:0]                   count;
  logic                               err_ovf;

  modport master (
    output in_en, in_bk, in_adr, in_tid, in_emsk, in_data,
    input  stall, wr_en, wr_adr, wr_tid, wr_emsk, wr_data, count, err_ovf
  );

  modport slave (
    input  in_en, in_bk, in_adr, in_tid, in_emsk, in_data,
    output stall, wr_en, wr_adr, wr_tid, wr_emsk, wr_data, count, err_ovf
  );
endinterface

// File: rtl/ip4_rtl_spa_wbq.sv
// SPA write-back queue: compacts per-FU results into an in-order ring and drains
// the longest bank-distinct prefix to the RF bank write ports each cycle.
module ip4_rtl_spa_wbq #(
  parameter int NUM_FU    = 3,
  parameter int NUM_SP    = 8,
  parameter int WORD_BITS = 32,
  parameter int NUM_BK    = 4,
  parameter int ADR_BITS  = 6,
  parameter int TID_BITS  = 3,
  parameter int DEPTH     = 8
) (
  input logic                clk,
  input logic                rst_n,
  ip4_rtl_spa_wbq_if.slave   bus
);
  localparam int BK_W  = $clog2(NUM_BK);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DW    = NUM_SP * WORD_BITS;

  typedef struct packed {
    logic [BK_W-1:0]     bk;
    logic [ADR_BITS-1:0] adr;
    logic [TID_BITS-1:0] tid;
    logic [NUM_SP-1:0]   emsk;
    logic [DW-1:0]       data;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];

  logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       stall_q, stall_d;
  logic                       err_ovf_q, err_ovf_d;
  logic [NUM_BK-1:0]          wr_en_q, wr_en_d;
  logic [NUM_BK*ADR_BITS-1:0] wr_adr_q, wr_adr_d;
  logic [NUM_BK*TID_BITS-1:0] wr_tid_q, wr_tid_d;
  logic [NUM_BK*NUM_SP-1:0]   wr_emsk_q, wr_emsk_d;
  logic [NUM_BK*DW-1:0]       wr_data_q, wr_data_d;

  logic [CNT_W-1:0]  avail, pop_n, push_n, free_n;
  logic [NUM_BK-1:0] bk_used;
  logic              pop_stop;
  logic [PTR_W-1:0]  pop_idx, push_idx;

  // Pop selection: longest in-order prefix of registered entries with distinct banks.
  always_comb begin
    avail     = (count_q > CNT_W'(NUM_BK)) ? CNT_W'(NUM_BK) : count_q;
    pop_n     = '0;
    bk_used   = '0;
    pop_stop  = 1'b0;
    pop_idx   = '0;
    wr_en_d   = '0;
    wr_adr_d  = '0;
    wr_tid_d  = '0;
    wr_emsk_d = '0;
    wr_data_d = '0;
    for (int k = 0; k < NUM_BK; k++) begin
      pop_idx = head_q + PTR_W'(k);
      if (!pop_stop && (CNT_W'(k) < avail) && !bk_used[ent_q[pop_idx].bk]) begin
        bk_used[ent_q[pop_idx].bk] = 1'b1;
        pop_n = pop_n + CNT_W'(1);
        for (int b = 0; b < NUM_BK; b++) begin
          if (ent_q[pop_idx].bk == BK_W'(b)) begin
            wr_en_d[b]                          = 1'b1;
            wr_adr_d[b*ADR_BITS +: ADR_BITS]    = ent_q[pop_idx].adr;
            wr_tid_d[b*TID_BITS +: TID_BITS]    = ent_q[pop_idx].tid;
            wr_emsk_d[b*NUM_SP +: NUM_SP]       = ent_q[pop_idx].emsk;
            wr_data_d[b*DW +: DW]               = ent_q[pop_idx].data;
          end else begin
            wr_en_d[b] = wr_en_d[b];
          end
        end
      end else begin
        pop_stop = 1'b1;
      end
    end
  end

  // Push compaction into the ring; free space ignores this cycle's pops, excess lanes drop.
  always_comb begin
    ent_d     = ent_q;
    free_n    = CNT_W'(DEPTH) - count_q;
    push_n    = '0;
    push_idx  = '0;
    err_ovf_d = err_ovf_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (bus.in_en[i] && (push_n < free_n)) begin
        push_idx             = tail_q + push_n[PTR_W-1:0];
        ent_d[push_idx].bk   = bus.in_bk[i*BK_W +: BK_W];
        ent_d[push_idx].adr  = bus.in_adr[i*ADR_BITS +: ADR_BITS];
        ent_d[push_idx].tid  = bus.in_tid;
        ent_d[push_idx].emsk = bus.in_emsk[i*NUM_SP +: NUM_SP];
        ent_d[push_idx].data = bus.in_data[i*DW +: DW];
        push_n               = push_n + CNT_W'(1);
      end else if (bus.in_en[i]) begin
        err_ovf_d = 1'b1;
      end else begin
        err_ovf_d = err_ovf_d;
      end
    end
    count_d = count_q + push_n - pop_n;
    head_d  = head_q + pop_n[PTR_W-1:0];
    tail_d  = tail_q + push_n[PTR_W-1:0];
    stall_d = (count_d > CNT_W'(DEPTH - NUM_FU));
  end

  // State and registered write-port outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        ent_q[e] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      stall_q   <= 1'b0;
      err_ovf_q <= 1'b0;
      wr_en_q   <= '0;
      wr_adr_q  <= '0;
      wr_tid_q  <= '0;
      wr_emsk_q <= '0;
      wr_data_q <= '0;
    end else begin
      ent_q     <= ent_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      stall_q   <= stall_d;
      err_ovf_q <= err_ovf_d;
      wr_en_q   <= wr_en_d;
      wr_adr_q  <= wr_adr_d;
      wr_tid_q  <= wr_tid_d;
      wr_emsk_q <= wr_emsk_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.stall   = stall_q;
  assign bus.count   = count_q;
  assign bus.err_ovf = err_ovf_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_adr  = wr_adr_q;
  assign bus.wr_tid  = wr_tid_q;
  assign bus.wr_emsk = wr_emsk_q;
  assign bus.wr_data = wr_data_q;
endmodule
